// File: rtl/operand_fetch_if.sv
// Operand fetch bus: fetch request/indices, writeback port, operand results.
//
// Handshake: start is a request level sampled on a rising edge only while the
// fetcher is idle or done (busy = 0); a request seen while busy = 1 is dropped,
// not queued. rn/rm are captured on the accepting edge. done is a one-cycle
// strobe marking aout/bout valid; there is no back-pressure from the consumer.
interface operand_fetch_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
);
   logic              start;
   logic [ADDR_W-1:0] rn;
   logic [ADDR_W-1:0] rm;
   logic              write;
   logic [ADDR_W-1:0] writenum;
   logic [DATA_W-1:0] data_in;
   logic [DATA_W-1:0] aout;
   logic [DATA_W-1:0] bout;
   logic              busy;
   logic              done;
   logic [1:0]        dbg_state;   // FSM state, exposed for checkers

   modport master (
      output start, rn, rm, write, writenum, data_in,
      input  aout, bout, busy, done, dbg_state
   );

   modport slave (
      input  start, rn, rm, write, writenum, data_in,
      output aout, bout, busy, done, dbg_state
   );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch: 2**ADDR_W x DATA_W register file with one combinational read
// port and one write port. A fetch reads operand A then operand B through the
// single read port; bout feeds the shifter input, aout the ALU A-side.
module operand_fetch #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
) (
   input  logic            clk,
   input  logic            reset,
   operand_fetch_if.slave  bus
);
   localparam int NREGS = 1 << ADDR_W;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      READ_A = 2'd1,
      READ_B = 2'd2,
      DONE   = 2'd3
   } state_t;

   logic [DATA_W-1:0] r_regs [NREGS];
   state_t            r_state;
   logic [ADDR_W-1:0] r_rn_q;
   logic [ADDR_W-1:0] r_rm_q;
   logic [DATA_W-1:0] r_aout;
   logic [DATA_W-1:0] r_bout;

   logic [ADDR_W-1:0] w_rd_idx;
   logic [DATA_W-1:0] w_rd_data;

   // Write port: independent of the FSM; reads in the same cycle see the old value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      end else if (bus.write) begin
         r_regs[bus.writenum] <= bus.data_in;
      end
   end

   // Single read port: B index only while reading B, otherwise A index.
   assign w_rd_idx  = (r_state == READ_B) ? r_rm_q : r_rn_q;
   assign w_rd_data = r_regs[w_rd_idx];

   // Fetch sequencer: capture indices on accept, latch A, then B, then report done.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_rn_q  <= '0;
         r_rm_q  <= '0;
         r_aout  <= '0;
         r_bout  <= '0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (bus.start) begin
                  r_rn_q  <= bus.rn;
                  r_rm_q  <= bus.rm;
                  r_state <= READ_A;
               end else begin
                  r_state <= IDLE;
               end
            end
            READ_A: begin
               r_aout  <= w_rd_data;
               r_state <= READ_B;
            end
            READ_B: begin
               r_bout  <= w_rd_data;
               r_state <= DONE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.aout      = r_aout;
   assign bus.bout      = r_bout;
   assign bus.busy      = (r_state == READ_A) || (r_state == READ_B);
   assign bus.done      = (r_state == DONE);
   assign bus.dbg_state = r_state;
endmodule
